// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract sequencer: FSM encoding and
// the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must index WIDTH bit positions; clamp so WIDTH=1 misuse still elaborates.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, the shared datapath of the serial add sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
// Handshake: start is sampled only in IDLE (sub/op_a/op_b with it); busy is
// high in RUN and DONE; done pulses for one cycle when result/cout are valid.
// A start seen while busy is dropped, never queued.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] s_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits enter at the MSB; after WIDTH shifts bit 0 holds the first (LSB) sum.
  assign s_next = {fa_sum, s_sh};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= fa_cout;
          s_sh  <= s_next[WIDTH-1:1];
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            result <= s_next;
            cout   <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // Carry into the MSB differing from carry out of it means signed overflow.
            ovf    <= carry ^ fa_cout;
`endif
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed add/sub vectors, dropped
// starts, back-to-back start after done, and mid-run reset abort.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];   // {ovf, cout, result}
  int           start_q[$]; // cycle stamp of the accepted start edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic         done_d = 1'b0;
  logic [W+1:0] mon_e;
  int           mon_s;

  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_single_pulse", {30'd0, done_d, done}, 32'h1);
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = start_q.pop_front();
        check("result", {24'd0, result}, {24'd0, mon_e[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, mon_e[W]});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, mon_e[W+1]});
`endif
        check("latency", cyc - mon_s, W);
      end
    end
    done_d = done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'h0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] exp_r, input logic exp_c, input logic exp_v);
    int bc;
    int t;
    @(negedge clk);
    wait_idle();
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back({exp_v, exp_c, exp_r});
    start_q.push_back(cyc);
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    sub   = ~s;
    bc = 0;
    t  = 0;
    while (busy && t < 50) begin
      bc++;
      @(negedge clk);
      t++;
    end
    check("busy_cycles", bc, W + 1);
    repeat (2) @(negedge clk);
    check("result_hold", {24'd0, result}, {24'd0, exp_r});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    check("rst_result", {24'd0, result}, 32'h0);
    check("rst_cout", {31'd0, cout}, 32'h0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'h0);
`endif
    rst_n = 1'b1;

    //    a      b      sub   result cout ovf
    do_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    do_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Starts during RUN and DONE are dropped; start in the cycle after done is taken.
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h46});
    start_q.push_back(cyc);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, done}, 32'h1);
    start = 1'b1; op_a = 8'hAA; op_b = 8'h55; sub = 1'b1;
    @(negedge clk);
    check("idle_after_done", {31'd0, busy}, 32'h0);
    op_a = 8'h20; op_b = 8'h30; sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'hF0});
    start_q.push_back(cyc);
    start = 1'b0;
    check("busy_after_restart", {31'd0, busy}, 32'h1);
    wait_idle();

    // Reset sampled at the 4th RUN edge aborts the operation.
    @(negedge clk);
    start = 1'b1; op_a = 8'h3C; op_b = 8'h0F; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_done", {31'd0, done}, 32'h0);
    check("abort_result", {24'd0, result}, 32'h0);
    check("abort_cout", {31'd0, cout}, 32'h0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", {31'd0, busy}, 32'h0);
    check("abort_result_held", {24'd0, result}, 32'h0);

    do_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
